// File: rtl/btb_predictor_if.sv
// Fetch/EX-side bundle of the branch target buffer.
// master: pipeline side (drives fetch PC and EX resolution); slave: the BTB.
interface btb_predictor_if #(
   parameter int unsigned PC_WIDTH = 32
);
   logic [PC_WIDTH-1:0] if_pc;
   logic                pred_hit;
   logic                pred_taken;
   logic [PC_WIDTH-1:0] pred_target;
   logic                ex_valid;
   logic [PC_WIDTH-1:0] ex_pc;
   logic [1:0]          ex_taken_type;
   logic [PC_WIDTH-1:0] ex_target;
   logic                ex_pred_hit;
   logic                ex_pred_taken;
   logic [PC_WIDTH-1:0] ex_pred_target;
   logic                inval_all;
   logic                flush;
   logic [PC_WIDTH-1:0] redirect_pc;
   logic [31:0]         perf_lookups;
   logic [31:0]         perf_mispred;

   modport master (
      output if_pc, ex_valid, ex_pc, ex_taken_type, ex_target,
             ex_pred_hit, ex_pred_taken, ex_pred_target, inval_all,
      input  pred_hit, pred_taken, pred_target, flush, redirect_pc,
             perf_lookups, perf_mispred
   );

   modport slave (
      input  if_pc, ex_valid, ex_pc, ex_taken_type, ex_target,
             ex_pred_hit, ex_pred_taken, ex_pred_target, inval_all,
      output pred_hit, pred_taken, pred_target, flush, redirect_pc,
             perf_lookups, perf_mispred
   );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Zero-latency prediction at IF, resolution/allocation at EX, invalidate-all.
// Optional feature macro: BTB_PERF_CNT_EN (resolved-branch and flush counters).
module btb_predictor #(
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned ENTRY_COUNT = 16,
   parameter logic [1:0]  CNT_INIT    = 2'b10
) (
   input  logic              clk,
   input  logic              rst_n,
   btb_predictor_if.slave    bus
);
   localparam int unsigned IDX       = $clog2(ENTRY_COUNT);
   localparam int unsigned TAG_WIDTH = PC_WIDTH - 2 - IDX;

   logic [ENTRY_COUNT-1:0] r_valid;
   logic [TAG_WIDTH-1:0]   r_tag    [ENTRY_COUNT];
   logic [PC_WIDTH-1:0]    r_target [ENTRY_COUNT];
   logic [1:0]             r_cnt    [ENTRY_COUNT];

   logic [IDX-1:0]       w_if_idx;
   logic [TAG_WIDTH-1:0] w_if_tag;
   logic                 w_if_hit;
   logic [IDX-1:0]       w_ex_idx;
   logic [TAG_WIDTH-1:0] w_ex_tag;
   logic                 w_ex_hit;
   logic                 w_is_br;
   logic                 w_nonbr;
   logic                 w_taken;
   logic                 w_flush;
   logic [PC_WIDTH-1:0]  w_redirect;
   logic                 w_alloc;
   logic                 w_upd_hit;
   logic                 w_alias;
   logic [1:0]           w_cnt_next;
   logic                 w_unused;

   assign w_if_idx = bus.if_pc[IDX+1:2];
   assign w_if_tag = bus.if_pc[PC_WIDTH-1:IDX+2];
   assign w_ex_idx = bus.ex_pc[IDX+1:2];
   assign w_ex_tag = bus.ex_pc[PC_WIDTH-1:IDX+2];
   assign w_unused = ^{bus.if_pc[1:0], bus.ex_pred_hit};

   // Fetch-side lookup on registered state
   always_comb begin
      w_if_hit        = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
      bus.pred_hit    = w_if_hit;
      bus.pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
      bus.pred_target = w_if_hit ? r_target[w_if_idx] : '0;
   end

   // EX resolution: mispredict detection, redirect and update decisions
   always_comb begin
      w_is_br    = bus.ex_valid && (bus.ex_taken_type != 2'b00);
      w_nonbr    = bus.ex_valid && (bus.ex_taken_type == 2'b00);
      w_taken    = bus.ex_valid && ((bus.ex_taken_type == 2'b01) ||
                                    (bus.ex_taken_type == 2'b10));
      w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
      w_flush    = (w_is_br && ((w_taken != bus.ex_pred_taken) ||
                                (w_taken && bus.ex_pred_taken &&
                                 (bus.ex_target != bus.ex_pred_target)))) ||
                   (w_nonbr && bus.ex_pred_taken);
      w_redirect = w_taken ? bus.ex_target : (bus.ex_pc + PC_WIDTH'(4));
      w_alloc    = w_is_br && !w_ex_hit && w_taken;
      w_upd_hit  = w_is_br && w_ex_hit;
      w_alias    = w_nonbr && w_ex_hit;
      w_cnt_next = r_cnt[w_ex_idx];
      if (w_taken) begin
         if (r_cnt[w_ex_idx] != 2'd3) w_cnt_next = r_cnt[w_ex_idx] + 2'd1;
      end else begin
         if (r_cnt[w_ex_idx] != 2'd0) w_cnt_next = r_cnt[w_ex_idx] - 2'd1;
      end
      bus.flush       = w_flush;
      bus.redirect_pc = w_flush ? w_redirect : '0;
   end

   // Entry storage: invalidate-all wins over any same-cycle EX update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRY_COUNT; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_cnt[i]    <= 2'd0;
         end
      end else if (bus.inval_all) begin
         r_valid <= '0;
      end else if (w_alloc) begin
         r_valid[w_ex_idx]  <= 1'b1;
         r_tag[w_ex_idx]    <= w_ex_tag;
         r_target[w_ex_idx] <= bus.ex_target;
         r_cnt[w_ex_idx]    <= CNT_INIT;
      end else if (w_upd_hit) begin
         r_cnt[w_ex_idx] <= w_cnt_next;
         if (w_taken) r_target[w_ex_idx] <= bus.ex_target;
      end else if (w_alias) begin
         r_valid[w_ex_idx] <= 1'b0;
      end
   end

`ifdef BTB_PERF_CNT_EN
   logic [31:0] r_perf_lookups;
   logic [31:0] r_perf_mispred;

   // Wrapping event counters, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_lookups <= 32'd0;
         r_perf_mispred <= 32'd0;
      end else begin
         if (w_is_br) r_perf_lookups <= r_perf_lookups + 32'd1;
         if (w_flush) r_perf_mispred <= r_perf_mispred + 32'd1;
      end
   end

   assign bus.perf_lookups = r_perf_lookups;
   assign bus.perf_mispred = r_perf_mispred;
`else
   assign bus.perf_lookups = 32'd0;
   assign bus.perf_mispred = 32'd0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed table-driven bench for btb_predictor (ENTRY_COUNT=16, PC_WIDTH=32).
module tb_btb_predictor;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   exp_lk;
   int   exp_mp;

   btb_predictor_if #(.PC_WIDTH(32)) bus ();

   btb_predictor #(.PC_WIDTH(32), .ENTRY_COUNT(16), .CNT_INIT(2'b10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ev;
      logic [1:0]  ty;
      logic [31:0] epc;
      logic [31:0] etgt;
      logic        ph;
      logic        pt;
      logic [31:0] ptg;
      logic        inv;
      logic [31:0] ipc;
      logic        fl;
      logic [31:0] rpc;
      logic        hit;
      logic        tk;
      logic [31:0] tgt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic ev, input logic [1:0] ty,
                               input logic [31:0] epc, input logic [31:0] etgt,
                               input logic ph, input logic pt, input logic [31:0] ptg,
                               input logic inv, input logic [31:0] ipc,
                               input logic fl, input logic [31:0] rpc,
                               input logic hit, input logic tk, input logic [31:0] tgt);
      vec_t v;
      v.ev = ev; v.ty = ty; v.epc = epc; v.etgt = etgt;
      v.ph = ph; v.pt = pt; v.ptg = ptg; v.inv = inv; v.ipc = ipc;
      v.fl = fl; v.rpc = rpc; v.hit = hit; v.tk = tk; v.tgt = tgt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle(input logic [31:0] ipc);
      bus.if_pc          = ipc;
      bus.ex_valid       = 1'b0;
      bus.ex_pc          = 32'h0;
      bus.ex_taken_type  = 2'b00;
      bus.ex_target      = 32'h0;
      bus.ex_pred_hit    = 1'b0;
      bus.ex_pred_taken  = 1'b0;
      bus.ex_pred_target = 32'h0;
      bus.inval_all      = 1'b0;
   endtask

   task automatic chk_lookup(input string tag, input logic hit, input logic tk,
                             input logic [31:0] tgt);
      chk($sformatf("%s pred_hit", tag),    32'(bus.pred_hit),   32'(hit));
      chk($sformatf("%s pred_taken", tag),  32'(bus.pred_taken), 32'(tk));
      chk($sformatf("%s pred_target", tag), bus.pred_target,     tgt);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_lk   = 0;
      exp_mp   = 0;

      //        ev ty     ex_pc         ex_tgt        ph pt pred_tgt      inv if_pc         fl redirect      hit tk target
      vecs.push_back(mk(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,   0, 32'h100, 0, 32'h0,   0, 0, 32'h0));
      vecs.push_back(mk(1, 2'b01, 32'h100,      32'h200,      0, 0, 32'h0,   0, 32'h100, 1, 32'h200, 0, 0, 32'h0));
      vecs.push_back(mk(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,   0, 32'h100, 0, 32'h0,   1, 1, 32'h200));
      vecs.push_back(mk(1, 2'b11, 32'h100,      32'h0,        1, 1, 32'h200, 0, 32'h100, 1, 32'h104, 1, 1, 32'h200));
      vecs.push_back(mk(1, 2'b11, 32'h100,      32'h0,        1, 0, 32'h200, 0, 32'h100, 0, 32'h0,   1, 0, 32'h200));
      vecs.push_back(mk(1, 2'b11, 32'h100,      32'h0,        1, 0, 32'h200, 0, 32'h100, 0, 32'h0,   1, 0, 32'h200));
      vecs.push_back(mk(1, 2'b01, 32'h100,      32'h200,      1, 0, 32'h200, 0, 32'h100, 1, 32'h200, 1, 0, 32'h200));
      vecs.push_back(mk(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,   0, 32'h100, 0, 32'h0,   1, 0, 32'h200));
      vecs.push_back(mk(1, 2'b01, 32'h100,      32'h200,      1, 0, 32'h200, 0, 32'h100, 1, 32'h200, 1, 0, 32'h200));
      vecs.push_back(mk(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,   0, 32'h100, 0, 32'h0,   1, 1, 32'h200));
      vecs.push_back(mk(1, 2'b01, 32'h100,      32'h240,      1, 1, 32'h200, 0, 32'h100, 1, 32'h240, 1, 1, 32'h200));
      vecs.push_back(mk(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,   0, 32'h100, 0, 32'h0,   1, 1, 32'h240));
      vecs.push_back(mk(1, 2'b10, 32'h100,      32'h240,      1, 1, 32'h240, 0, 32'h100, 0, 32'h0,   1, 1, 32'h240));
      vecs.push_back(mk(1, 2'b11, 32'h100,      32'h0,        1, 1, 32'h240, 0, 32'h100, 1, 32'h104, 1, 1, 32'h240));
      vecs.push_back(mk(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,   0, 32'h100, 0, 32'h0,   1, 1, 32'h240));
      vecs.push_back(mk(1, 2'b01, 32'h140,      32'h300,      0, 0, 32'h0,   0, 32'h140, 1, 32'h300, 0, 0, 32'h0));
      vecs.push_back(mk(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,   0, 32'h100, 0, 32'h0,   0, 0, 32'h0));
      vecs.push_back(mk(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,   0, 32'h140, 0, 32'h0,   1, 1, 32'h300));
      vecs.push_back(mk(1, 2'b00, 32'h140,      32'h0,        1, 1, 32'h300, 0, 32'h140, 1, 32'h144, 1, 1, 32'h300));
      vecs.push_back(mk(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,   0, 32'h140, 0, 32'h0,   0, 0, 32'h0));
      vecs.push_back(mk(1, 2'b00, 32'h200,      32'h0,        0, 0, 32'h0,   0, 32'h200, 0, 32'h0,   0, 0, 32'h0));
      vecs.push_back(mk(0, 2'b01, 32'h180,      32'h400,      0, 0, 32'h0,   0, 32'h180, 0, 32'h0,   0, 0, 32'h0));
      vecs.push_back(mk(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,   0, 32'h180, 0, 32'h0,   0, 0, 32'h0));
      vecs.push_back(mk(1, 2'b11, 32'h180,      32'h0,        0, 0, 32'h0,   0, 32'h180, 0, 32'h0,   0, 0, 32'h0));
      vecs.push_back(mk(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,   0, 32'h180, 0, 32'h0,   0, 0, 32'h0));
      vecs.push_back(mk(1, 2'b11, 32'hFFFFFFFC, 32'h0,        1, 1, 32'h40,  0, 32'h180, 1, 32'h0,   0, 0, 32'h0));
      vecs.push_back(mk(1, 2'b10, 32'h104,      32'h500,      0, 0, 32'h0,   0, 32'h104, 1, 32'h500, 0, 0, 32'h0));
      vecs.push_back(mk(1, 2'b01, 32'h108,      32'h600,      0, 0, 32'h0,   1, 32'h104, 1, 32'h600, 1, 1, 32'h500));
      vecs.push_back(mk(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,   0, 32'h104, 0, 32'h0,   0, 0, 32'h0));
      vecs.push_back(mk(0, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,   0, 32'h108, 0, 32'h0,   0, 0, 32'h0));

      // Reset: every lookup misses, during and right after reset
      rst_n = 1'b0;
      drive_idle(32'h100);
      repeat (2) @(negedge clk);
      #1;
      chk_lookup("reset 0x100", 1'b0, 1'b0, 32'h0);
      bus.if_pc = 32'h140;
      #1;
      chk_lookup("reset 0x140", 1'b0, 1'b0, 32'h0);
      chk("reset flush", 32'(bus.flush), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk_lookup("post-reset 0x140", 1'b0, 1'b0, 32'h0);

      // Vector table: inputs held for one cycle, outputs checked before the edge
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         bus.ex_valid       = vecs[i].ev;
         bus.ex_taken_type  = vecs[i].ty;
         bus.ex_pc          = vecs[i].epc;
         bus.ex_target      = vecs[i].etgt;
         bus.ex_pred_hit    = vecs[i].ph;
         bus.ex_pred_taken  = vecs[i].pt;
         bus.ex_pred_target = vecs[i].ptg;
         bus.inval_all      = vecs[i].inv;
         bus.if_pc          = vecs[i].ipc;
         #1;
         chk($sformatf("v%0d flush", i),       32'(bus.flush),  32'(vecs[i].fl));
         chk($sformatf("v%0d redirect_pc", i), bus.redirect_pc, vecs[i].rpc);
         chk_lookup($sformatf("v%0d", i), vecs[i].hit, vecs[i].tk, vecs[i].tgt);
         if (vecs[i].ev && (vecs[i].ty != 2'b00)) exp_lk++;
         if (vecs[i].fl) exp_mp++;
      end

      @(negedge clk);
      drive_idle(32'h100);
      #1;
`ifdef BTB_PERF_CNT_EN
      chk("perf_lookups", bus.perf_lookups, 32'(exp_lk));
      chk("perf_mispred", bus.perf_mispred, 32'(exp_mp));
`else
      chk("perf_lookups tied", bus.perf_lookups, 32'h0);
      chk("perf_mispred tied", bus.perf_mispred, 32'h0);
`endif

      // Reset asserted mid-operation clears a live entry without a clock edge
      bus.ex_valid      = 1'b1;
      bus.ex_taken_type = 2'b01;
      bus.ex_pc         = 32'h100;
      bus.ex_target     = 32'h700;
      @(negedge clk);
      drive_idle(32'h100);
      #1;
      chk_lookup("realloc 0x100", 1'b1, 1'b1, 32'h700);
      #2;
      rst_n = 1'b0;
      #1;
      chk_lookup("async reset 0x100", 1'b0, 1'b0, 32'h0);
      chk("async reset perf_lookups", bus.perf_lookups, 32'h0);
      chk("async reset perf_mispred", bus.perf_mispred, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk_lookup("after reset release 0x100", 1'b0, 1'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
